// File: rtl/filter_pkg.sv
// filter_pkg: shared constants and state type
// for the stream frame scheduler.
package filter_pkg;

  localparam int BYTE_W        = 8;
  localparam int FRAME_LEN_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    FETCH,
    SEND,
    GAP
  } sched_state_t;

endpackage

// File: rtl/stream_frame_sched_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
// Pointer holds the last granted source.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (update && gnt != 2'b00)
      last <= gnt[1];
  end

endmodule

// File: rtl/stream_frame_sched.sv
// stream_frame_sched: two-source frame scheduler.
// Optional frame counter: SCHED_FRAME_STATS_EN.
module stream_frame_sched
  import filter_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic [7:0]        rd_addr,
  input  logic [BYTE_W-1:0] rd_data0,
  input  logic [BYTE_W-1:0] rd_data1,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam logic [7:0] LAST =
    8'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_INIT =
    4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t state;
  logic [7:0]   addr;
  logic [3:0]   gap_cnt;
  logic         sel;
  logic [1:0]   arb_gnt;

  assign busy = (state != IDLE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (state == ARB),
    .gnt    (arb_gnt)
  );

  // rd_addr runs one byte ahead of out_data so
  // the sync buffer read overlaps the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rd_addr   <= 8'd0;
      addr      <= 8'd0;
      gap_cnt   <= 4'd0;
      sel       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      grant <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|req)
            state <= ARB;
        end
        ARB: begin
          if (arb_gnt != 2'b00) begin
            grant   <= arb_gnt;
            sel     <= arb_gnt[1];
            addr    <= 8'd0;
            rd_addr <= 8'd0;
            state   <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          out_data  <= sel ? rd_data1 : rd_data0;
          out_valid <= 1'b1;
          out_last  <= (addr == LAST);
          if (addr != LAST)
            rd_addr <= addr + 8'd1;
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              addr    <= 8'd0;
              rd_addr <= 8'd0;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                gap_cnt <= GAP_INIT;
                state   <= GAP;
              end
            end else begin
              addr  <= addr + 8'd1;
              state <= FETCH;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_FRAME_STATS_EN
  logic done;
  assign done = (state == SEND) && out_valid
             && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= 16'd0;
    else if (done && frame_cnt != 16'hFFFF)
      frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_stream_frame_sched.sv
// tb_stream_frame_sched: directed bench over
// three scheduler configurations.
module tb_stream_frame_sched;

  localparam int NI = 3;
  localparam int FL [NI] = '{4, 256, 1};
  localparam int GP [NI] = '{4, 4, 0};
`ifdef SCHED_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [NI-1:0][1:0]  req;
  logic [NI-1:0][1:0]  grant;
  logic [NI-1:0][7:0]  ra;
  logic [NI-1:0][7:0]  rd0;
  logic [NI-1:0][7:0]  rd1;
  logic [NI-1:0][7:0]  od;
  logic [NI-1:0]       ov;
  logic [NI-1:0]       rdy;
  logic [NI-1:0]       ol;
  logic [NI-1:0]       busy;
  logic [NI-1:0][15:0] fc;

  int total;
  int bad;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    stream_frame_sched #(
      .FRAME_LEN  (FL[g]),
      .GAP_CYCLES (GP[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req[g]),
      .grant     (grant[g]),
      .rd_addr   (ra[g]),
      .rd_data0  (rd0[g]),
      .rd_data1  (rd1[g]),
      .out_data  (od[g]),
      .out_valid (ov[g]),
      .out_ready (rdy[g]),
      .out_last  (ol[g]),
      .busy      (busy[g]),
      .frame_cnt (fc[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] mem(
    input int i, input logic s,
    input logic [7:0] a);
    case (i)
      0:       return s ? 8'hB0 + a : 8'hA0 + a;
      1:       return s ? ~a : a ^ 8'h5A;
      default: return s ? 8'h3C : 8'hC3;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rd0[i] <= mem(i, 1'b0, ra[i]);
      rd1[i] <= mem(i, 1'b1, ra[i]);
    end
  end

  logic [7:0] hd   [NI][0:511];
  logic       hl   [NI][0:511];
  int         hc   [NI][0:511];
  logic [1:0] glog [NI][0:15];
  int hn [NI];
  int gn [NI];
  int fd [NI];
  int gapc [NI];
  int gapv [NI];
  logic al   [NI];
  logic r255 [NI];
  logic z255 [NI];
  int cyc;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        al[i]   <= 1'b0;
        r255[i] <= 1'b0;
        z255[i] <= 1'b0;
      end else begin
        if (busy[i] && ra[i] == 8'hFF && !al[i])
          r255[i] <= 1'b1;
        if (busy[i] && ra[i] == 8'h00
            && r255[i] && !al[i])
          z255[i] <= 1'b1;
        if (grant[i] != 2'b00) begin
          if (gn[i] < 16)
            glog[i][gn[i]] <= grant[i];
          gn[i] <= gn[i] + 1;
        end
        if (ov[i] && rdy[i]) begin
          if (hn[i] < 512) begin
            hd[i][hn[i]] <= od[i];
            hl[i][hn[i]] <= ol[i];
            hc[i][hn[i]] <= cyc;
          end
          hn[i] <= hn[i] + 1;
          if (ol[i]) begin
            fd[i]   <= fd[i] + 1;
            al[i]   <= 1'b1;
            gapc[i] <= 0;
            gapv[i] <= 0;
            r255[i] <= 1'b0;
          end
        end else if (al[i]) begin
          if (busy[i]) begin
            gapc[i] <= gapc[i] + 1;
            if (ov[i])
              gapv[i] <= gapv[i] + 1;
          end else begin
            al[i] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic serve(input int i,
                       input logic [1:0] r,
                       input bit keep,
                       input int nfr,
                       input int stall_at,
                       input int bound);
    int f0, h0, ok;
    bit stalled, done;
    logic [7:0] sd;
    f0 = fd[i];
    h0 = hn[i];
    stalled = 1'b0;
    done = 1'b0;
    req[i] = r;
    rdy[i] = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk); #1;
      if (!keep)
        req[i] = req[i] & ~grant[i];
      if (!stalled && ov[i]
          && hn[i] - h0 == stall_at) begin
        stalled = 1'b1;
        sd = od[i];
        rdy[i] = 1'b0;
        ok = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (ov[i] && od[i] == sd && !ol[i])
            ok++;
        end
        chk("stall_hold", ok, 5);
        chk("stall_data", sd,
            mem(i, 1'b0, 8'(stall_at)));
        @(posedge clk); #1;
        rdy[i] = 1'b1;
      end
      if (fd[i] - f0 >= nfr && !busy[i]) begin
        done = 1'b1;
        break;
      end
    end
    req[i] = 2'b00;
    chk($sformatf("serve_done%0d", i), done, 1);
  endtask

  int g0, h0, h1, err;
  logic [15:0] fexp;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req = '0;
    rdy = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_valid%0d", i), ov[i], 0);
      chk($sformatf("rst_last%0d", i), ol[i], 0);
      chk($sformatf("rst_grant%0d", i), grant[i], 0);
      chk($sformatf("rst_data%0d", i), od[i], 0);
      chk($sformatf("rst_addr%0d", i), ra[i], 0);
      chk($sformatf("rst_fcnt%0d", i), fc[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // single source, four-byte frame
    g0 = gn[0];
    h0 = hn[0];
    serve(0, 2'b01, 1'b0, 1, -1, 200);
    chk("t1_ngrant", gn[0] - g0, 1);
    chk("t1_grant", glog[0][g0], 2'b01);
    chk("t1_nbytes", hn[0] - h0, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_data%0d", k),
          hd[0][h0+k], mem(0, 1'b0, 8'(k)));
      chk($sformatf("t1_last%0d", k),
          hl[0][h0+k], (k == 3));
    end
    chk("t1_rate", hc[0][h0+3] - hc[0][h0], 6);
    chk("t1_gap", gapc[0], 4);
    chk("t1_gapvalid", gapv[0], 0);
    chk("t1_idle", busy[0], 0);
    fexp = STATS ? 16'd1 : 16'd0;
    chk("t1_fcnt", fc[0], fexp);

    // both sources, three frames
    do_rst();
    g0 = gn[0];
    h0 = hn[0];
    serve(0, 2'b11, 1'b1, 3, -1, 400);
    chk("t2_ngrant", gn[0] - g0, 3);
    chk("t2_g0", glog[0][g0], 2'b01);
    chk("t2_g1", glog[0][g0+1], 2'b10);
    chk("t2_g2", glog[0][g0+2], 2'b01);
    err = 0;
    for (int k = 0; k < 4; k++)
      if (hd[0][h0+4+k] != mem(0, 1'b1, 8'(k)))
        err++;
    chk("t2_src1_data", err, 0);
    fexp = STATS ? 16'd3 : 16'd0;
    chk("t2_fcnt", fc[0], fexp);

    // backpressure on byte 2
    h0 = hn[0];
    serve(0, 2'b01, 1'b0, 1, 2, 300);
    chk("t3_nbytes", hn[0] - h0, 4);
    err = 0;
    for (int k = 0; k < 4; k++)
      if (hd[0][h0+k] != mem(0, 1'b0, 8'(k))
          || hl[0][h0+k] != (k == 3))
        err++;
    chk("t3_bytes", err, 0);
    fexp = STATS ? 16'd4 : 16'd0;
    chk("t3_fcnt", fc[0], fexp);

    // reset mid-frame on the 256-byte build
    do_rst();
    h0 = hn[1];
    req[1] = 2'b01;
    rdy[1] = 1'b1;
    err = 1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      req[1] = req[1] & ~grant[1];
      if (hn[1] - h0 >= 100) begin
        err = 0;
        break;
      end
    end
    chk("t4_reach100", err, 0);
    rst = 1'b1;
    rdy[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy[1] = 1'b1;
    @(negedge clk);
    chk("t4_valid", ov[1], 0);
    chk("t4_busy", busy[1], 0);
    chk("t4_data", od[1], 0);
    chk("t4_addr", ra[1], 0);
    chk("t4_fcnt", fc[1], 0);
    chk("t4_nbytes", hn[1] - h0, 100);

    h1 = hn[1];
    serve(1, 2'b01, 1'b0, 1, -1, 1000);
    chk("t5_nbytes", hn[1] - h1, 256);
    chk("t5_first", hd[1][h1], 8'h5A);
    chk("t5_lastbyte", hd[1][h1+255],
        mem(1, 1'b0, 8'hFF));
    chk("t5_lastflag", hl[1][h1+255], 1);
    err = 0;
    for (int k = 0; k < 256; k++)
      if (hd[1][h1+k] != mem(1, 1'b0, 8'(k))
          || hl[1][h1+k] != (k == 255))
        err++;
    chk("t5_bytes", err, 0);
    chk("t5_nowrap", z255[1], 0);
    fexp = STATS ? 16'd1 : 16'd0;
    chk("t5_fcnt", fc[1], fexp);

    // dropped request, then one-byte frame
    g0 = gn[2];
    @(posedge clk); #1;
    req[2] = 2'b01;
    @(posedge clk); #1;
    req[2] = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_nogrant", gn[2] - g0, 0);
    chk("t6_idle", busy[2], 0);

    h0 = hn[2];
    serve(2, 2'b10, 1'b0, 1, -1, 50);
    chk("t6_ngrant", gn[2] - g0, 1);
    chk("t6_grant", glog[2][g0], 2'b10);
    chk("t6_nbytes", hn[2] - h0, 1);
    chk("t6_data", hd[2][h0], 8'h3C);
    chk("t6_last", hl[2][h0], 1);
    chk("t6_busyfall", gapc[2], 0);
    fexp = STATS ? 16'd1 : 16'd0;
    chk("t6_fcnt", fc[2], fexp);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
